// File: rtl/clause_array_pkg.sv
// Shared literal/variable encodings, BCP state type and the lowest-set-bit
// helper used by the clause array.
package clause_array_pkg;

  localparam logic [1:0] LIT_ABSENT = 2'b00;
  localparam logic [1:0] LIT_POS    = 2'b01;
  localparam logic [1:0] LIT_NEG    = 2'b10;

  localparam logic [1:0] VAR_FREE   = 2'b00;
  localparam logic [1:0] VAR_TRUE   = 2'b01;
  localparam logic [1:0] VAR_FALSE  = 2'b10;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} bcp_state_e;

  // Two's-complement trick isolates the lowest set bit; callers size via casts.
  function automatic logic [63:0] lowest_set(input logic [63:0] v);
    return v & (~v + 64'd1);
  endfunction

endpackage

// File: rtl/clause_eval.sv
// Combinational evaluation of one clause against one assignment:
// satisfied / unit / conflict, plus the implied literal for a unit clause.
module clause_eval
  import clause_array_pkg::*;
#(
  parameter int NUM_VARS = 8,
  parameter int WIDTH_VI = $clog2(NUM_VARS)
) (
  input  logic [NUM_VARS*2-1:0] clause,
  input  logic [NUM_VARS*2-1:0] assignment,
  output logic                  sat,
  output logic                  unit,
  output logic                  conflict,
  output logic [WIDTH_VI-1:0]   unit_var,
  output logic                  unit_val
);

  function automatic logic lit_present(input logic [1:0] lit);
    return (lit == LIT_POS) || (lit == LIT_NEG);
  endfunction

  function automatic logic var_free(input logic [1:0] st);
    return (st == VAR_FREE) || (st == 2'b11);
  endfunction

  logic any_true;
  logic one_free;
  logic multi_free;

  // Track "seen one free literal" and "seen a second" instead of a counter.
  always_comb begin
    any_true   = 1'b0;
    one_free   = 1'b0;
    multi_free = 1'b0;
    unit_var   = '0;
    unit_val   = 1'b0;
    for (int v = 0; v < NUM_VARS; v++) begin
      if ((clause[2*v +: 2] == LIT_POS && assignment[2*v +: 2] == VAR_TRUE) ||
          (clause[2*v +: 2] == LIT_NEG && assignment[2*v +: 2] == VAR_FALSE))
        any_true = 1'b1;
      if (lit_present(clause[2*v +: 2]) && var_free(assignment[2*v +: 2])) begin
        if (one_free) begin
          multi_free = 1'b1;
        end else begin
          one_free = 1'b1;
          unit_var = WIDTH_VI'(v);
          unit_val = (clause[2*v +: 2] == LIT_POS);
        end
      end
    end
  end

  assign sat      = any_true;
  assign unit     = !any_true && one_free && !multi_free;
  assign conflict = !any_true && !one_free;

endmodule

// File: rtl/clause_array_bcp.sv
// Clause store with learnt-slot allocation and a one-clause-per-cycle
// Boolean constraint propagation engine emitting implications via valid/ready.
module clause_array_bcp
  import clause_array_pkg::*;
#(
  parameter int NUM_CLAUSES = 8,
  parameter int NUM_VARS    = 8,
  parameter int WIDTH_CI    = $clog2(NUM_CLAUSES),
  parameter int WIDTH_VI    = $clog2(NUM_VARS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CLAUSES-1:0] wr_i,
  input  logic [NUM_VARS*2-1:0]  clause_i,
  input  logic                   learnt_wr_i,
  output logic                   learnt_full_o,
  output logic [NUM_CLAUSES-1:0] learntc_insert_index_o,
  input  logic [NUM_VARS*2-1:0]  var_value_i,
  output logic [NUM_VARS*2-1:0]  var_value_o,
  input  logic                   start_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic                   impl_valid_o,
  input  logic                   impl_ready_i,
  output logic [WIDTH_VI-1:0]    impl_var_o,
  output logic                   impl_val_o,
  output logic [WIDTH_CI-1:0]    impl_clause_o,
  output logic                   done_o,
  output logic                   conflict_o,
  output logic [WIDTH_CI-1:0]    conflict_clause_o
);

  localparam logic [WIDTH_CI-1:0] LAST_IDX = WIDTH_CI'(NUM_CLAUSES - 1);

  function automatic logic slot_valid(input logic [NUM_VARS*2-1:0] c);
    logic any;
    any = 1'b0;
    for (int v = 0; v < NUM_VARS; v++)
      if (c[2*v +: 2] != LIT_ABSENT && c[2*v +: 2] != 2'b11) any = 1'b1;
    return any;
  endfunction

  logic [NUM_VARS*2-1:0]  mem      [NUM_CLAUSES];
  logic [NUM_VARS*2-1:0]  mem_next [NUM_CLAUSES];
  logic [NUM_CLAUSES-1:0] free_next;

  bcp_state_e            state;
  logic [WIDTH_CI-1:0]   idx;
  logic                  pass_impl;

  logic                  ev_sat;
  logic                  ev_unit;
  logic                  ev_conflict;
  logic [WIDTH_VI-1:0]   ev_var;
  logic                  ev_val;
  logic                  cur_valid;

  // Writes only land in IDLE; a direct write pre-empts a learnt insert.
  always_comb begin
    for (int c = 0; c < NUM_CLAUSES; c++) mem_next[c] = mem[c];
    if (state == IDLE) begin
      if (|wr_i) begin
        for (int c = 0; c < NUM_CLAUSES; c++)
          if (wr_i[c]) mem_next[c] = clause_i;
      end else if (learnt_wr_i) begin
        for (int c = 0; c < NUM_CLAUSES; c++)
          if (learntc_insert_index_o[c]) mem_next[c] = clause_i;
      end
    end
    free_next = '0;
    for (int c = 0; c < NUM_CLAUSES; c++) free_next[c] = !slot_valid(mem_next[c]);
  end

  // The insert index is computed from the post-write contents so it is current
  // one cycle after any write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CLAUSES; c++) mem[c] <= '0;
      learntc_insert_index_o <= NUM_CLAUSES'(1);
      learnt_full_o          <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CLAUSES; c++) mem[c] <= mem_next[c];
      learntc_insert_index_o <= NUM_CLAUSES'(lowest_set(64'(free_next)));
      learnt_full_o          <= (state == IDLE) && learnt_wr_i && !(|wr_i) &&
                                !(|learntc_insert_index_o);
    end
  end

  assign cur_valid = slot_valid(mem[idx]);

  clause_eval #(
    .NUM_VARS (NUM_VARS),
    .WIDTH_VI (WIDTH_VI)
  ) u_eval (
    .clause     (mem[idx]),
    .assignment (var_value_o),
    .sat        (ev_sat),
    .unit       (ev_unit),
    .conflict   (ev_conflict),
    .unit_var   (ev_var),
    .unit_val   (ev_val)
  );

  assign busy_o = (state != IDLE);

  // After an accepted implication at the last slot, another pass is always due.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      idx               <= '0;
      pass_impl         <= 1'b0;
      var_value_o       <= '0;
      impl_valid_o      <= 1'b0;
      impl_var_o        <= '0;
      impl_val_o        <= 1'b0;
      impl_clause_o     <= '0;
      done_o            <= 1'b0;
      conflict_o        <= 1'b0;
      conflict_clause_o <= '0;
    end else if (state != IDLE && abort_i) begin
      state        <= IDLE;
      impl_valid_o <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            var_value_o       <= var_value_i;
            idx               <= '0;
            pass_impl         <= 1'b0;
            conflict_o        <= 1'b0;
            conflict_clause_o <= '0;
            state             <= SCAN;
          end
        end
        SCAN: begin
          if (cur_valid && !ev_sat && ev_conflict) begin
            conflict_o        <= 1'b1;
            conflict_clause_o <= idx;
            done_o            <= 1'b1;
            state             <= DONE;
          end else if (cur_valid && ev_unit) begin
            impl_valid_o  <= 1'b1;
            impl_var_o    <= ev_var;
            impl_val_o    <= ev_val;
            impl_clause_o <= idx;
            state         <= EMIT;
          end else if (idx == LAST_IDX) begin
            if (pass_impl) begin
              pass_impl <= 1'b0;
              idx       <= '0;
            end else begin
              done_o <= 1'b1;
              state  <= DONE;
            end
          end else begin
            idx <= idx + WIDTH_CI'(1);
          end
        end
        EMIT: begin
          if (impl_ready_i) begin
            var_value_o[2*impl_var_o +: 2] <= impl_val_o ? VAR_TRUE : VAR_FALSE;
            impl_valid_o <= 1'b0;
            state        <= SCAN;
            if (idx == LAST_IDX) begin
              idx       <= '0;
              pass_impl <= 1'b0;
            end else begin
              idx       <= idx + WIDTH_CI'(1);
              pass_impl <= 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clause_array_bcp.sv
// Scoreboard bench for clause_array_bcp: expected implications are queued
// when a run starts and popped by a monitor on each handshake.
module tb_clause_array_bcp;

  localparam int NC = 8;
  localparam int NV = 8;
  localparam logic [1:0] POS = 2'b01;
  localparam logic [1:0] NEG = 2'b10;

  typedef struct packed {
    logic [2:0] var_idx;
    logic       val;
    logic [2:0] clause;
  } impl_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NC-1:0]   wr_i = '0;
  logic [2*NV-1:0] clause_i = '0;
  logic            learnt_wr_i = 1'b0;
  logic            learnt_full_o;
  logic [NC-1:0]   learntc_insert_index_o;
  logic [2*NV-1:0] var_value_i = '0;
  logic [2*NV-1:0] var_value_o;
  logic            start_i = 1'b0;
  logic            abort_i = 1'b0;
  logic            busy_o;
  logic            impl_valid_o;
  logic            impl_ready_i = 1'b1;
  logic [2:0]      impl_var_o;
  logic            impl_val_o;
  logic [2:0]      impl_clause_o;
  logic            done_o;
  logic            conflict_o;
  logic [2:0]      conflict_clause_o;

  int    compared   = 0;
  int    mismatched = 0;
  int    impl_seen  = 0;
  impl_t exp_q[$];

  clause_array_bcp #(.NUM_CLAUSES(NC), .NUM_VARS(NV)) dut (
    .clk(clk), .rst(rst), .wr_i(wr_i), .clause_i(clause_i),
    .learnt_wr_i(learnt_wr_i), .learnt_full_o(learnt_full_o),
    .learntc_insert_index_o(learntc_insert_index_o),
    .var_value_i(var_value_i), .var_value_o(var_value_o),
    .start_i(start_i), .abort_i(abort_i), .busy_o(busy_o),
    .impl_valid_o(impl_valid_o), .impl_ready_i(impl_ready_i),
    .impl_var_o(impl_var_o), .impl_val_o(impl_val_o),
    .impl_clause_o(impl_clause_o), .done_o(done_o),
    .conflict_o(conflict_o), .conflict_clause_o(conflict_clause_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*NV-1:0] lit(input int v, input logic [1:0] code);
    logic [2*NV-1:0] r;
    r = '0;
    r[2*v +: 2] = code;
    return r;
  endfunction

  // Handshake monitor: every accepted implication must match the queue head.
  always @(negedge clk) begin
    if (!rst && impl_valid_o && impl_ready_i) begin
      impl_t e;
      impl_seen++;
      checkOutput("impl_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("impl_var", 32'(impl_var_o), 32'(e.var_idx));
        checkOutput("impl_val", 32'(impl_val_o), 32'(e.val));
        checkOutput("impl_clause", 32'(impl_clause_o), 32'(e.clause));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic writeClause(input int slot, input logic [2*NV-1:0] c);
    wr_i     = NC'(1) << slot;
    clause_i = c;
    tick();
    wr_i     = '0;
  endtask

  task automatic loadFive();
    writeClause(0, lit(0, NEG) | lit(2, POS));
    writeClause(1, lit(1, POS) | lit(3, POS) | lit(5, NEG));
    writeClause(2, lit(0, NEG) | lit(3, POS) | lit(4, NEG));
    writeClause(3, lit(0, POS) | lit(1, POS) | lit(4, POS));
    writeClause(4, lit(1, POS) | lit(2, NEG) | lit(4, NEG));
  endtask

  task automatic learntWrite(input logic [2*NV-1:0] c);
    learnt_wr_i = 1'b1;
    clause_i    = c;
    tick();
    learnt_wr_i = 1'b0;
  endtask

  // Starts a run and returns the cycle (counted from start) when done_o shows.
  task automatic applyStimulus(input logic [2*NV-1:0] vv, output int cycles);
    var_value_i = vv;
    start_i     = 1'b1;
    cycles      = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      cycles++;
      start_i = 1'b0;
      if (done_o) break;
    end
    start_i = 1'b0;
    checkOutput("done_seen", 32'(done_o), 32'd1);
  endtask

  initial begin
    int cyc;
    int dones;
    rst = 1'b1;
    tick();
    // Reset state
    checkOutput("rst_insert_idx", 32'(learntc_insert_index_o), 32'h01);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    checkOutput("rst_conflict", 32'(conflict_o), 32'd0);
    checkOutput("rst_var_value", 32'(var_value_o), 32'd0);
    checkOutput("rst_impl_valid", 32'(impl_valid_o), 32'd0);
    checkOutput("rst_learnt_full", 32'(learnt_full_o), 32'd0);
    rst = 1'b0;
    tick();

    // Slot allocation and learnt overflow
    loadFive();
    checkOutput("insert_after_five", 32'(learntc_insert_index_o), 32'h20);
    learntWrite(lit(6, POS));
    checkOutput("insert_after_l5", 32'(learntc_insert_index_o), 32'h40);
    learntWrite(lit(6, NEG));
    checkOutput("insert_after_l6", 32'(learntc_insert_index_o), 32'h80);
    learntWrite(lit(7, POS));
    checkOutput("insert_full", 32'(learntc_insert_index_o), 32'h00);
    checkOutput("full_no_pulse_yet", 32'(learnt_full_o), 32'd0);
    learntWrite(lit(7, NEG));
    checkOutput("full_pulse", 32'(learnt_full_o), 32'd1);
    tick();
    checkOutput("full_pulse_end", 32'(learnt_full_o), 32'd0);
    writeClause(7, '0);
    checkOutput("insert_after_free", 32'(learntc_insert_index_o), 32'h80);

    // All free: clean single pass
    resetDut();
    loadFive();
    impl_seen = 0;
    applyStimulus('0, cyc);
    checkOutput("free_done_cycle", 32'(cyc), 32'd9);
    checkOutput("free_conflict", 32'(conflict_o), 32'd0);
    checkOutput("free_impls", 32'(impl_seen), 32'd0);

    // x0 true: one implication then a clean second pass
    resetDut();
    loadFive();
    impl_seen = 0;
    exp_q.push_back('{var_idx: 3'd2, val: 1'b1, clause: 3'd0});
    applyStimulus(lit(0, POS), cyc);
    checkOutput("unit_done_cycle", 32'(cyc), 32'd18);
    checkOutput("unit_impls", 32'(impl_seen), 32'd1);
    checkOutput("unit_leftover", 32'(exp_q.size()), 32'd0);
    checkOutput("unit_conflict", 32'(conflict_o), 32'd0);
    checkOutput("unit_var_value", 32'(var_value_o), 32'h0011);

    // x0 true, x2 false: immediate conflict on clause 0
    resetDut();
    loadFive();
    impl_seen = 0;
    applyStimulus(lit(0, POS) | lit(2, NEG), cyc);
    checkOutput("conf_done_cycle", 32'(cyc), 32'd2);
    checkOutput("conf_flag", 32'(conflict_o), 32'd1);
    checkOutput("conf_clause", 32'(conflict_clause_o), 32'd0);
    checkOutput("conf_impls", 32'(impl_seen), 32'd0);
    tick();
    checkOutput("conf_held", 32'(conflict_o), 32'd1);
    checkOutput("done_one_cycle", 32'(done_o), 32'd0);

    // Backpressure: five stalled cycles, then one handshake
    resetDut();
    loadFive();
    impl_seen    = 0;
    impl_ready_i = 1'b0;
    exp_q.push_back('{var_idx: 3'd2, val: 1'b1, clause: 3'd0});
    var_value_i  = lit(0, POS);
    start_i      = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 20 && !impl_valid_o; i++) tick();
    checkOutput("bp_valid_seen", 32'(impl_valid_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_valid_stable", 32'(impl_valid_o), 32'd1);
      checkOutput("bp_var_stable", 32'(impl_var_o), 32'd2);
      checkOutput("bp_val_stable", 32'(impl_val_o), 32'd1);
      checkOutput("bp_clause_stable", 32'(impl_clause_o), 32'd0);
    end
    impl_ready_i = 1'b1;
    for (int i = 0; i < 100 && !done_o; i++) tick();
    checkOutput("bp_done", 32'(done_o), 32'd1);
    checkOutput("bp_impls", 32'(impl_seen), 32'd1);
    checkOutput("bp_leftover", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset during SCAN clears FSM and clause memory
    resetDut();
    loadFive();
    var_value_i = lit(0, POS) | lit(2, NEG);
    start_i     = 1'b1;
    tick();
    start_i = 1'b0;
    checkOutput("pre_rst_busy", 32'(busy_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_busy", 32'(busy_o), 32'd0);
    checkOutput("async_rst_var", 32'(var_value_o), 32'd0);
    checkOutput("async_rst_conflict", 32'(conflict_o), 32'd0);
    checkOutput("async_rst_insert", 32'(learntc_insert_index_o), 32'h01);
    tick();
    rst = 1'b0;
    tick();
    applyStimulus(lit(0, POS) | lit(2, NEG), cyc);
    checkOutput("rst_mem_cleared_cycle", 32'(cyc), 32'd9);
    checkOutput("rst_mem_cleared_conf", 32'(conflict_o), 32'd0);

    // Abort during EMIT: idle next cycle, no done pulse, working copy kept
    resetDut();
    loadFive();
    impl_seen    = 0;
    impl_ready_i = 1'b0;
    var_value_i  = lit(0, POS);
    start_i      = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 20 && !impl_valid_o; i++) tick();
    checkOutput("abort_in_emit", 32'(impl_valid_o), 32'd1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checkOutput("abort_busy", 32'(busy_o), 32'd0);
    checkOutput("abort_valid", 32'(impl_valid_o), 32'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_o) dones++;
      tick();
    end
    checkOutput("abort_no_done", 32'(dones), 32'd0);
    checkOutput("abort_var_kept", 32'(var_value_o), 32'h0001);
    checkOutput("abort_impls", 32'(impl_seen), 32'd0);
    impl_ready_i = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
